// File: rtl/sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// sram_burst_ctrl
//
// Burst access controller for a single-port synchronous SRAM with one cycle of
// read latency. One command is accepted at a time. The start address is
// latched and then auto-incremented, wrapping modulo 2^ADDR_W. Write beats
// arrive on a valid/ready stream and go straight to the SRAM. Read beats
// leave through a 2-entry return buffer, so the consumer can apply arbitrary
// backpressure.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   cmd_*            command handshake: write/read select, start address,
//                    length (beats minus one)
//   wr_valid/ready   write beat stream, wr_data is the beat
//   rd_valid/ready   read beat stream, rd_data is the beat
//   done             one-cycle pulse when a burst finishes
//   mem_*            SRAM macro side; mem_r_data is valid the cycle after
//                    mem_r_en
// -----------------------------------------------------------------------------
module sram_burst_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              mem_en,
    output logic              mem_w_en,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W:0]    ISSUE_ONE = (LEN_W + 1)'(1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [LEN_W-1:0]    remaining_reg, remaining_next;
    logic [LEN_W:0]      issue_left_reg, issue_left_next;
    logic                done_reg, done_next;
    logic                inflight_reg;

    // Return buffer: two entries addressed by one-bit pointers.
    logic [DATA_W-1:0]   buf_reg [2];
    logic [1:0]          count_reg;
    logic                wr_ptr_reg;
    logic                rd_ptr_reg;

    logic                issue;
    logic                push;
    logic                rd_fire;
    logic [2:0]          pending;

    // Data returned by the SRAM lands in the buffer at the end of the cycle
    // after the read strobe, which is exactly the cycle the inflight flag is set.
    assign push     = inflight_reg;
    assign rd_valid = (count_reg != 2'd0);
    assign rd_fire  = rd_valid && rd_ready;
    assign rd_data  = rd_valid ? buf_reg[rd_ptr_reg] : '0;
    assign done     = done_reg;

    // Beats already committed to the buffer (stored or still in the SRAM pipe).
    assign pending  = 3'(count_reg) + 3'(inflight_reg);

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        remaining_next  = remaining_reg;
        issue_left_next = issue_left_reg;
        done_next       = 1'b0;
        cmd_ready       = 1'b0;
        wr_ready        = 1'b0;
        mem_en          = 1'b0;
        mem_w_en        = 1'b0;
        mem_r_en        = 1'b0;
        mem_addr        = '0;
        mem_w_data      = '0;
        issue           = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // The state register is already IDLE while rst is high; the
                // gate only keeps cmd_ready low for the duration of reset.
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    addr_next       = cmd_addr;
                    remaining_next  = cmd_len;
                    issue_left_next = {1'b0, cmd_len} + ISSUE_ONE;
                    state_next      = cmd_write ? WRITE : READ;
                end
            end

            WRITE: begin
                mem_en     = 1'b1;
                wr_ready   = 1'b1;
                mem_addr   = addr_reg;
                mem_w_data = wr_data;
                mem_w_en   = wr_valid;
                if (wr_valid) begin
                    addr_next = addr_reg + ADDR_ONE;
                    if (remaining_reg == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        remaining_next = remaining_reg - LEN_ONE;
                    end
                end
            end

            READ: begin
                mem_en   = 1'b1;
                mem_addr = addr_reg;
                // Issue only if the beat is guaranteed a buffer slot; a pop in
                // this same cycle frees one, which keeps full rate at rd_ready=1.
                issue    = (issue_left_reg != '0) && (pending < (3'd2 + 3'(rd_fire)));
                mem_r_en = issue;
                if (issue) begin
                    addr_next       = addr_reg + ADDR_ONE;
                    issue_left_next = issue_left_reg - ISSUE_ONE;
                end
                if (rd_fire) begin
                    if (remaining_reg == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        remaining_next = remaining_reg - LEN_ONE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            remaining_reg  <= '0;
            issue_left_reg <= '0;
            done_reg       <= 1'b0;
            inflight_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            remaining_reg  <= remaining_next;
            issue_left_reg <= issue_left_next;
            done_reg       <= done_next;
            inflight_reg   <= issue;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (rd_fire) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + 2'(push) - 2'(rd_fire);
        end
    end

    // Storage needs no reset: rd_data is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_reg[wr_ptr_reg] <= mem_r_data;
        end
    end

endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Parametrised burst access controller for a single-port synchronous SRAM macro with 1-cycle read latency. It sits between a command/stream front end (pad mux, scan/DFT host or systolic-array loader) and the SRAM wrapper. It accepts one burst command at a time and auto-increments the address with wrap-around. Write data arrives on a valid/ready stream; read data leaves on a valid/ready stream with full backpressure through a 2-entry return buffer.

## Interface
- DATA_W, 8, data word width
- ADDR_W, 8, SRAM address width; depth = 2^ADDR_W
- LEN_W, 4, burst length field width; max burst = 2^LEN_W beats
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle, command accepted on valid&&ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  LEN_W  beats minus one
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat accepted
- wr_data  in  DATA_W  write beat
- rd_valid  out  1  read beat available
- rd_ready  in  1  consumer takes read beat
- rd_data  out  DATA_W  read beat
- done  out  1  one-cycle pulse, burst complete
- mem_en  out  1  SRAM macro enable
- mem_w_en  out  1  SRAM write strobe
- mem_r_en  out  1  SRAM read strobe
- mem_addr  out  ADDR_W  SRAM address, shared by read and write
- mem_w_data  out  DATA_W  SRAM write data
- mem_r_data  in  DATA_W  SRAM read data, valid the cycle after mem_r_en

## Operation
- States: IDLE, WRITE, READ. Reset forces IDLE, clears the address and beat counters, clears the return buffer and the in-flight flag, and clears done.
- While rst is high, every output is 0, including cmd_ready.
- IDLE behaviour:
  - cmd_ready=1.
  - On handshake, latch cmd_addr into addr_q and cmd_len into remaining_q.
  - Go to WRITE or READ according to cmd_write.
- WRITE behaviour:
  - wr_ready=1.
  - mem_w_en = wr_valid, combinational; mem_addr=addr_q; mem_w_data=wr_data.
  - Each write handshake increments addr_q modulo 2^ADDR_W.
  - When the handshake beat has remaining_q==0, go to IDLE; otherwise decrement remaining_q.
- READ behaviour, issue side:
  - mem_r_en=1 when issue_left>0 and (occupancy + inflight − pop) < 2, where pop = rd_valid&&rd_ready.
  - Each issue increments addr_q with wrap.
  - issue_left starts at cmd_len+1.
- READ behaviour, return side:
  - The inflight flag is set for one cycle after each issue.
  - mem_r_data is pushed into the 2-entry FIFO on the edge ending the inflight cycle.
  - rd_valid = FIFO non-empty; rd_data = FIFO head.
  - Each rd handshake decrements remaining_q. On the final beat, go to IDLE.
- mem_en=1 whenever state≠IDLE.
- done pulses for one cycle on entry to IDLE from WRITE or READ.
- cmd_valid outside IDLE is ignored; there is no queuing.
- Read data order equals address order. No beat is dropped or duplicated under any rd_ready pattern.
- rd_data is stable while rd_valid&&!rd_ready.
- A write burst followed immediately by a read burst of the same addresses returns the written data; the write completes before cmd_ready rises.

## Timing
- Command handshake at cycle t: cmd_ready=0 and the state is active from t+1.
- Write: beat handshake at cycle t drives mem_w_en in the same cycle t. One beat per cycle is sustained.
- Read: first mem_r_en at t+1, data captured at the end of t+2, first rd_valid at t+3.
- With rd_ready held at 1, one beat per cycle is delivered with no gaps.
- Final beat handshake at cycle f: done=1 and cmd_ready=1 at f+1. The next command can be accepted at f+1.
- Asynchronous rst mid-burst has the following effects:
  - Outputs drop to 0 immediately and remaining read data is discarded.
  - After rst falls, cmd_ready=1 on the first cycle.
  - No mem strobe is asserted until a new command is accepted.
- A cmd_len of 0 produces exactly one beat. A cmd_len of all-ones produces 2^LEN_W beats.

## Test plan
- Reset mid-burst: assert rst during a READ of len 7 at the 3rd beat. Required: all outputs go to 0 in the same cycle. After release, cmd_ready=1, rd_valid=0, and mem_r_en=0 until a new command.
- Write burst: cmd_write=1, addr 0x10, len 3, data A0,A1,A2,A3 back-to-back. Required: mem_w_en high for 4 consecutive cycles at addresses 0x10–0x13, then done pulses once and cmd_ready rises.
- Read burst, full rate: read addr 0x10, len 3, rd_ready=1. Required: rd_valid rises 3 cycles after accept, and A0–A3 appear on 4 consecutive cycles followed by done.
- Backpressure: same read with rd_ready pattern 1,0,0,1,0,1,1. Required: the sequence A0–A3 is preserved with no loss, at most 2 entries are buffered, and rd_data is stable while stalled.
- Wrap and single beat: write at addr 0xFE, len 3. Required: addresses FE,FF,00,01. Then read at addr 0xFF, len 0. Required: exactly one beat, matching the value written to 0xFF.
- Busy command: pulse cmd_valid during a WRITE. Required: not accepted, burst unaffected, and a single done pulse.
